// File: rtl/core_ras.sv
// Return-address stack: speculative fetch-side stack over a circular buffer.
// Optional macro CORE_RAS_RECOVER_EN adds commit-side pointers that are restored on flush.
module core_ras #(
    parameter int RAS_DEPTH = 8,
    parameter int PTR_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ras_go,
    input  logic             push,
    input  logic [31:0]      push_addr,
    input  logic             pop,
    input  logic             flush,
    input  logic             c_push,
    input  logic             c_pop,
    output logic [31:0]      ras_target,
    output logic             ras_v,
    output logic [PTR_W:0]   ras_cnt
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);

    typedef struct packed {
        logic [PTR_W-1:0] tos;
        logic [PTR_W:0]   cnt;
    } ptr_t;

    // Shared pointer rule for both fetch and commit sides; push+pop on a
    // non-empty stack replaces the top, otherwise push wins, empty pop is ignored.
    function automatic ptr_t advance(input ptr_t p, input logic pu, input logic po);
        ptr_t r;
        r = p;
        if (pu && po && (p.cnt != '0)) begin
            r = p;
        end else if (pu) begin
            r.tos = p.tos + PTR_W'(1);
            if (p.cnt != FULL) r.cnt = p.cnt + (PTR_W+1)'(1);
        end else if (po && (p.cnt != '0)) begin
            r.tos = p.tos - PTR_W'(1);
            r.cnt = p.cnt - (PTR_W+1)'(1);
        end
        return r;
    endfunction

    logic [31:0]      mem_q [RAS_DEPTH];
    ptr_t             sp_q, sp_d, sp_adv;
    logic             we;
    logic [PTR_W-1:0] waddr;

`ifdef CORE_RAS_RECOVER_EN
    ptr_t c_q, c_d;

    always_comb begin
        c_d = advance(c_q, c_push, c_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) c_q <= '0;
        else     c_q <= c_d;
    end
`else
    logic unused_commit;
    assign unused_commit = c_push ^ c_pop;
`endif

    always_comb begin
        sp_adv = advance(sp_q, push, pop);
        sp_d   = sp_q;
        we     = 1'b0;
        waddr  = (pop && (sp_q.cnt != '0)) ? sp_q.tos : sp_q.tos + PTR_W'(1);
        if (flush) begin
`ifdef CORE_RAS_RECOVER_EN
            sp_d = c_d;
`else
            sp_d = '0;
`endif
        end else if (ras_go) begin
            sp_d = sp_adv;
            we   = push;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) sp_q <= '0;
        else     sp_q <= sp_d;
    end

    // Entries are intentionally left unreset; cnt alone governs validity.
    always_ff @(posedge clk) begin
        if (we && !rst) mem_q[waddr] <= push_addr;
    end

    assign ras_v      = (sp_q.cnt != '0);
    assign ras_cnt    = sp_q.cnt;
    assign ras_target = ras_v ? mem_q[sp_q.tos] : '0;

endmodule

// File: tb/tb_core_ras.sv
// Directed self-checking bench for core_ras (DEPTH 8); expectations follow CORE_RAS_RECOVER_EN.
module tb_core_ras;

    logic        clk = 1'b0;
    logic        rst, ras_go, push, pop, flush, c_push, c_pop;
    logic [31:0] push_addr;
    logic [31:0] ras_target;
    logic        ras_v;
    logic [3:0]  ras_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_ras #(.RAS_DEPTH(8), .PTR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .ras_go     (ras_go),
        .push       (push),
        .push_addr  (push_addr),
        .pop        (pop),
        .flush      (flush),
        .c_push     (c_push),
        .c_pop      (c_pop),
        .ras_target (ras_target),
        .ras_v      (ras_v),
        .ras_cnt    (ras_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; flush = 1'b0; c_push = 1'b0; c_pop = 1'b0;
        ras_go = 1'b1; rst = 1'b0; push_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_push(input logic [31:0] a);
        push = 1'b1; push_addr = a; tick();
    endtask

    task automatic do_pop();
        pop = 1'b1; tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick();
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset();
        do_reset();
        check("reset_cnt", 32'(ras_cnt), 32'd0);
        check("reset_v", 32'(ras_v), 32'd0);
        check("reset_target", ras_target, 32'h0);

        // basic LIFO
        do_push(32'h00040010);
        check("push1_target", ras_target, 32'h00040010);
        do_push(32'h00040020);
        do_push(32'h00040030);
        check("push3_target", ras_target, 32'h00040030);
        check("push3_cnt", 32'(ras_cnt), 32'd3);
        do_pop();
        check("pop1_target", ras_target, 32'h00040020);
        do_pop();
        check("pop2_target", ras_target, 32'h00040010);
        check("pop2_cnt", 32'(ras_cnt), 32'd1);
        do_pop();
        check("pop3_v", 32'(ras_v), 32'd0);
        check("pop3_target", ras_target, 32'h0);

        // overflow wraps over the oldest entry
        for (int i = 1; i <= 9; i++) do_push(32'h100 * i);
        check("ovf_cnt", 32'(ras_cnt), 32'd8);
        check("ovf_target", ras_target, 32'h900);
        for (int i = 1; i <= 7; i++) begin
            do_pop();
            check($sformatf("ovf_pop%0d", i), ras_target, 32'h100 * (9 - i));
            check($sformatf("ovf_pop%0d_cnt", i), 32'(ras_cnt), 32'(8 - i));
        end
        do_pop();
        check("ovf_pop8_v", 32'(ras_v), 32'd0);
        check("ovf_pop8_target", ras_target, 32'h0);
        do_pop();
        check("underflow_cnt", 32'(ras_cnt), 32'd0);

        // push+pop replaces top
        do_push(32'h100);
        do_push(32'h200);
        push = 1'b1; pop = 1'b1; push_addr = 32'h300; tick();
        check("replace_target", ras_target, 32'h300);
        check("replace_cnt", 32'(ras_cnt), 32'd2);
        do_pop();
        check("replace_pop_target", ras_target, 32'h100);
        check("replace_pop_cnt", 32'(ras_cnt), 32'd1);

        // push+pop on empty stack acts as push
        do_pop();
        push = 1'b1; pop = 1'b1; push_addr = 32'h444; tick();
        check("empty_pp_cnt", 32'(ras_cnt), 32'd1);
        check("empty_pp_target", ras_target, 32'h444);

        // ras_go low holds everything
        ras_go = 1'b0; push = 1'b1; push_addr = 32'h500; tick();
        check("nogo_push_cnt", 32'(ras_cnt), 32'd1);
        check("nogo_push_target", ras_target, 32'h444);
        ras_go = 1'b0; pop = 1'b1; tick();
        check("nogo_pop_cnt", 32'(ras_cnt), 32'd1);

        // flush recovery
        do_reset();
        push = 1'b1; push_addr = 32'h100; c_push = 1'b1; tick();
        do_push(32'h200);
        check("pre_flush_target", ras_target, 32'h200);
        flush = 1'b1; push = 1'b1; push_addr = 32'h300; tick();
`ifdef CORE_RAS_RECOVER_EN
        check("flush_cnt", 32'(ras_cnt), 32'd1);
        check("flush_target", ras_target, 32'h100);
`else
        check("flush_cnt", 32'(ras_cnt), 32'd0);
        check("flush_v", 32'(ras_v), 32'd0);
        check("flush_target", ras_target, 32'h0);
`endif

        // reset dominates push and flush
        do_push(32'h600);
        do_push(32'h610);
        rst = 1'b1; push = 1'b1; flush = 1'b1; push_addr = 32'h620; tick();
        check("rst_dom_cnt", 32'(ras_cnt), 32'd0);
        check("rst_dom_v", 32'(ras_v), 32'd0);

        // flush is not gated by ras_go
        do_push(32'h700);
        check("pre_nogo_flush_cnt", 32'(ras_cnt), 32'd1);
        ras_go = 1'b0; flush = 1'b1; tick();
        check("nogo_flush_cnt", 32'(ras_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_ras.md
CORE_RAS -- requirements
Module: core_ras

Interface
REQ-001 Parameter RAS_DEPTH, default 8, number of return-address entries; SHALL be a power of two, 2..32.
REQ-002 Parameter PTR_W, default 3, pointer width; SHALL equal log2(RAS_DEPTH).
REQ-003 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ras_go  in  1  advance enable, same timing as the PC advance enable; push/pop SHALL be ignored when low.
REQ-006 push  in  1  fetch predicts a call (BTB hit, type jal).
REQ-007 push_addr  in  32  return address to push (PC+4 of the call).
REQ-008 pop  in  1  fetch predicts a return (BTB hit, type jr).
REQ-009 flush  in  1  decode redirect (decode-stage PC override); not gated by ras_go.
REQ-010 c_push  in  1  decode confirms a call (commit-side push).
REQ-011 c_pop  in  1  decode confirms a return (commit-side pop).
REQ-012 ras_target  out  32  predicted return address for the PC mux.
REQ-013 ras_v  out  1  stack non-empty.
REQ-014 ras_cnt  out  PTR_W+1  valid entry count, 0..RAS_DEPTH.

Function
REQ-015 Storage SHALL be a circular array mem[RAS_DEPTH] x 32 with speculative top pointer tos (PTR_W bits) and count cnt.
REQ-016 ras_target SHALL be combinational: mem[tos] when cnt>0, else 32'h00000000; ras_v = (cnt!=0); ras_cnt = cnt.
REQ-017 Push only (ras_go=1): tos<=tos+1 mod RAS_DEPTH; mem[tos+1]<=push_addr; cnt<=min(cnt+1,RAS_DEPTH).
REQ-018 Push when cnt==RAS_DEPTH SHALL overwrite the oldest entry; cnt stays RAS_DEPTH; no error flag.
REQ-019 Pop only (ras_go=1), cnt>0: tos<=tos-1 mod RAS_DEPTH; cnt<=cnt-1; mem unchanged.
REQ-020 Pop when cnt==0 SHALL leave tos, cnt, mem unchanged (underflow ignored).
REQ-021 Push and pop together, cnt>0: mem[tos]<=push_addr; tos, cnt unchanged (replace top).
REQ-022 Push and pop together, cnt==0: SHALL behave as push only.
REQ-023 ras_go=0: tos, cnt, mem SHALL hold, regardless of push/pop.
REQ-024 Commit state c_tos/c_cnt SHALL update from c_push/c_pop with the rules of REQ-017..REQ-022 applied to pointers only (no mem write), independent of ras_go.
REQ-025 flush SHALL take priority over push/pop in the same cycle; the fetch-side push/pop of that cycle are discarded.
REQ-026 Written entries become visible on ras_target the cycle after the write (one-cycle latency).

Reset
REQ-027 rst SHALL set tos=0, cnt=0, c_tos=0, c_cnt=0; ras_v=0, ras_cnt=0, ras_target=0 the cycle after.
REQ-028 mem contents SHALL NOT be reset.
REQ-029 rst SHALL dominate flush, push, pop, c_push, c_pop.

Configuration
REQ-030 Macro CORE_RAS_RECOVER_EN defined: on flush, tos<=c_tos' and cnt<=c_cnt', where primes denote commit state including same-cycle c_push/c_pop.
REQ-031 With CORE_RAS_RECOVER_EN, entries overwritten by wrong-path pushes are not restored; this is accepted prediction inaccuracy.
REQ-032 Macro undefined: commit state and c_push/c_pop SHALL be omitted (ports present, ignored); flush sets tos=0, cnt=0.

Verification
REQ-033 Reset, then push 0x00040010,0x00040020,0x00040030 -> ras_target 0x00040030, ras_cnt 3; three pops -> 0x00040020, 0x00040010, then ras_v=0, ras_target 0.
REQ-034 Nine pushes 0x100..0x900 (DEPTH 8) -> ras_cnt 8, ras_target 0x900; eight pops return 0x800..0x200 in order, then ras_v=0; ninth pop leaves ras_cnt 0.
REQ-035 Stack holds 0x100,0x200; push 0x300 with pop same cycle -> ras_target 0x300, ras_cnt 2; pop -> 0x100.
REQ-036 push 0x500 with ras_go=0 -> ras_cnt, ras_target unchanged next cycle.
REQ-037 Recover on: push 0x100 with c_push; push 0x200 (no commit); flush with push 0x300 -> ras_cnt 1, ras_target 0x100. Recover off: same -> ras_cnt 0, ras_v 0.
REQ-038 rst asserted while push=1, flush=1 -> ras_cnt 0, ras_v 0 next cycle.
